// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions: ALU command encodings, shift types,
// forwarding select codes and a rotate helper.
package arm_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam logic [1:0] FWD_ID  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // A shift by 32 yields zero, so amount 0 returns x unchanged.
  function automatic logic [31:0] rotr32(input logic [31:0] x, input logic [4:0] r);
    return (x >> r) | (x << (6'd32 - {1'b0, r}));
  endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ID/EXE input bundle and EXE outputs of the execute stage.
// master = upstream/pipeline side, slave = exe_stage.
interface exe_stage_if;

  logic        freeze;
  logic [31:0] pc_in;
  logic        mem_r_en_in;
  logic        mem_w_en_in;
  logic        wb_en_in;
  logic        status_w_en_in;
  logic        branch_taken_in;
  logic        imm_in;
  logic [3:0]  exec_cmd_in;
  logic [31:0] val_rn_in;
  logic [31:0] val_rm_in;
  logic [23:0] signed_immed_24_in;
  logic [3:0]  dest_in;
  logic [11:0] shift_operand_in;
  logic        carry_in;
  logic [1:0]  sel_src1;
  logic [1:0]  sel_src2;
  logic [31:0] mem_fwd_val;
  logic [31:0] wb_fwd_val;

  logic [31:0] branch_addr;
  logic        branch_taken;
  logic [3:0]  status;
  logic [31:0] alu_res;
  logic [31:0] st_val;
  logic [3:0]  dest;
  logic        wb_en;
  logic        mem_r_en;
  logic        mem_w_en;

  modport master (
    output freeze, pc_in, mem_r_en_in, mem_w_en_in, wb_en_in, status_w_en_in,
           branch_taken_in, imm_in, exec_cmd_in, val_rn_in, val_rm_in,
           signed_immed_24_in, dest_in, shift_operand_in, carry_in,
           sel_src1, sel_src2, mem_fwd_val, wb_fwd_val,
    input  branch_addr, branch_taken, status, alu_res, st_val, dest,
           wb_en, mem_r_en, mem_w_en
  );

  modport slave (
    input  freeze, pc_in, mem_r_en_in, mem_w_en_in, wb_en_in, status_w_en_in,
           branch_taken_in, imm_in, exec_cmd_in, val_rn_in, val_rm_in,
           signed_immed_24_in, dest_in, shift_operand_in, carry_in,
           sel_src1, sel_src2, mem_fwd_val, wb_fwd_val,
    output branch_addr, branch_taken, status, alu_res, st_val, dest,
           wb_en, mem_r_en, mem_w_en
  );

endinterface

// File: rtl/exe_stage_val2_gen.sv
// Second-operand generator: rotated 8-bit immediate, 12-bit memory offset,
// or Rm shifted by an immediate amount.
module val2_gen
  import arm_pkg::*;
(
  input  logic [31:0] val_rm,
  input  logic [11:0] shift_operand,
  input  logic        imm,
  input  logic        mem_en,
  output logic [31:0] val2
);

  logic [4:0] sh_amt;

  assign sh_amt = shift_operand[11:7];

  always_comb begin
    val2 = val_rm;
    if (imm) begin
      val2 = rotr32({24'b0, shift_operand[7:0]}, {shift_operand[11:8], 1'b0});
    end else if (mem_en) begin
      val2 = {20'b0, shift_operand};
    end else begin
      case (shift_operand[6:5])
        SH_LSL:  val2 = val_rm << sh_amt;
        SH_LSR:  val2 = val_rm >> sh_amt;
        SH_ASR:  val2 = $signed(val_rm) >>> sh_amt;
        default: val2 = rotr32(val_rm, sh_amt);
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, Val2 generation, ALU, NZCV register,
// branch target, EXE/MEM register. Define FORWARDING_EN to enable forwarding muxes.
module exe_stage
  import arm_pkg::*;
(
  input logic        clk,
  input logic        rst,
  exe_stage_if.slave bus
);

  logic [31:0] op1;
  logic [31:0] op2src;
  logic [31:0] val2;
  logic [31:0] b_op;
  logic        cin;
  logic        arith;
  logic [32:0] sum;
  logic [31:0] result;
  logic        v_flag;
  logic [3:0]  status_next;

  logic [3:0]  status_q;
  logic [31:0] alu_res_q;
  logic [31:0] st_val_q;
  logic [3:0]  dest_q;
  logic        wb_en_q;
  logic        mem_r_en_q;
  logic        mem_w_en_q;

`ifdef FORWARDING_EN
  always_comb begin
    case (bus.sel_src1)
      FWD_MEM: op1 = bus.mem_fwd_val;
      FWD_WB:  op1 = bus.wb_fwd_val;
      default: op1 = bus.val_rn_in;
    endcase
    case (bus.sel_src2)
      FWD_MEM: op2src = bus.mem_fwd_val;
      FWD_WB:  op2src = bus.wb_fwd_val;
      default: op2src = bus.val_rm_in;
    endcase
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{bus.sel_src1, bus.sel_src2, bus.mem_fwd_val, bus.wb_fwd_val};
  assign op1    = bus.val_rn_in;
  assign op2src = bus.val_rm_in;
`endif

  val2_gen u_val2_gen (
    .val_rm        (op2src),
    .shift_operand (bus.shift_operand_in),
    .imm           (bus.imm_in),
    .mem_en        (bus.mem_r_en_in | bus.mem_w_en_in),
    .val2          (val2)
  );

  // Subtraction runs through the same adder as Rn + ~Val2 + cin, so C means "no borrow".
  always_comb begin
    b_op   = val2;
    cin    = 1'b0;
    arith  = 1'b0;
    result = '0;
    case (bus.exec_cmd_in)
      CMD_MOV: result = val2;
      CMD_MVN: result = ~val2;
      CMD_ADD: arith = 1'b1;
      CMD_ADC: begin arith = 1'b1; cin = bus.carry_in; end
      CMD_SUB: begin arith = 1'b1; b_op = ~val2; cin = 1'b1; end
      CMD_SBC: begin arith = 1'b1; b_op = ~val2; cin = bus.carry_in; end
      CMD_AND: result = op1 & val2;
      CMD_ORR: result = op1 | val2;
      CMD_EOR: result = op1 ^ val2;
      default: result = '0;
    endcase
    sum = {1'b0, op1} + {1'b0, b_op} + {32'b0, cin};
    if (arith) result = sum[31:0];
    v_flag = (op1[31] == b_op[31]) && (sum[31] != op1[31]);
    status_next = {result[31], (result == 32'd0),
                   arith ? sum[32] : status_q[1],
                   arith ? v_flag  : status_q[0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= '0;
    end else if (bus.status_w_en_in && !bus.freeze) begin
      status_q <= status_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_res_q  <= '0;
      st_val_q   <= '0;
      dest_q     <= '0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
    end else if (!bus.freeze) begin
      alu_res_q  <= result;
      st_val_q   <= op2src;
      dest_q     <= bus.dest_in;
      wb_en_q    <= bus.wb_en_in;
      mem_r_en_q <= bus.mem_r_en_in;
      mem_w_en_q <= bus.mem_w_en_in;
    end
  end

  assign bus.branch_addr  = bus.pc_in + {{6{bus.signed_immed_24_in[23]}}, bus.signed_immed_24_in, 2'b00};
  assign bus.branch_taken = bus.branch_taken_in;
  assign bus.status       = status_q;
  assign bus.alu_res      = alu_res_q;
  assign bus.st_val       = st_val_q;
  assign bus.dest         = dest_q;
  assign bus.wb_en        = wb_en_q;
  assign bus.mem_r_en     = mem_r_en_q;
  assign bus.mem_w_en     = mem_w_en_q;

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the 5-stage ARM pipeline. It consumes the registered ID/EXE bundle and does four things: generates Val2, runs the ALU, updates the NZCV status register, and computes the branch target. It registers the result into an internal EXE/MEM pipeline register that feeds the memory stage. Branch target and taken flag go back to IF combinationally; flags go back to ID for condition checking.

## Interface
- FORWARDING: compile-time only, via `FORWARDING_EN` (see Configuration); no Verilog parameters.
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- freeze  in  1  hold EXE/MEM register and status register
- pc_in  in  32  PC+4 of instruction in EXE
- mem_r_en_in, mem_w_en_in, wb_en_in, status_w_en_in, branch_taken_in, imm_in  in  1 each  control from ID/EXE register
- exec_cmd_in  in  4  ALU command
- val_rn_in, val_rm_in  in  32  register operands
- signed_immed_24_in  in  24  branch offset (words)
- dest_in  in  4  destination register
- shift_operand_in  in  12  shifter operand / offset12
- carry_in  in  1  C flag captured at decode
- sel_src1, sel_src2  in  2  forwarding select: 00 ID, 01 MEM alu_res, 10 WB value, 11 = 00
- mem_fwd_val, wb_fwd_val  in  32  forwarded values
- branch_addr  out  32  pc_in + (sext(imm24) << 2), combinational
- branch_taken  out  1  = branch_taken_in, combinational
- status  out  4  NZCV register {N,Z,C,V}
- alu_res, st_val  out  32  registered ALU result / store data
- dest  out  4  registered
- wb_en, mem_r_en, mem_w_en  out  1  registered

## Operation
- Operands: op1 = forwarded Rn, op2src = forwarded Rm; st_val captures the forwarded Rm.
- Val2 selection:
  - imm_in=1: {24'b0, so[7:0]} rotated right by 2*so[11:8].
  - Else if mem_r_en_in|mem_w_en_in: {20'b0, so[11:0]}.
  - Else: Rm shifted by so[11:7] using type so[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. Shift amount 0 means no shift for every type.
- ALU by exec_cmd_in:
  - 0001 MOV: Val2
  - 1001 MVN: ~Val2
  - 0010 ADD: Rn+Val2
  - 0011 ADC: Rn+Val2+carry_in
  - 0100 SUB/CMP: Rn−Val2
  - 0101 SBC: Rn−Val2−~carry_in
  - 0110 AND/TST: &
  - 0111 ORR: |
  - 1000 EOR: ^
  - Any other code: result 0, flags C/V unchanged.
- Arithmetic is done at 33 bits; bit 32 is the carry out.
  - Subtract is Rn + ~Val2 + 1 (SBC: + carry_in), so C=1 means no borrow.
  - V = signed overflow: (a31==b31)&&(r31!=a31), with b = ~Val2 for subtract.
- Flags:
  - N = r[31], Z = (r==0) for every command.
  - C and V are updated only for ADD/ADC/SUB/SBC and retain their old values for logical and move commands.
- Status register loads on posedge when status_w_en_in && !freeze.
- EXE/MEM register loads alu_res, st_val, dest, wb_en, mem_r_en, mem_w_en on posedge when !freeze; it holds when freeze=1.
- Loads and stores use ADD, so alu_res is the effective address.

## Timing
- Reset: status=0, alu_res=0, st_val=0, dest=0, wb_en=0, mem_r_en=0, mem_w_en=0, applied immediately on rst.
- rst asserted mid-operation clears state the same cycle. The first capture happens on the first posedge after rst deasserts.
- Latency: branch_addr and branch_taken are combinational in the same cycle. ALU result is visible at the EXE/MEM output one posedge later.
- Status is written at the same posedge as EXE/MEM; the ID stage sees the new flags next cycle.
- Simultaneous freeze and status_w_en_in: freeze wins and nothing updates.
- Branches have wb_en_in=0 and status_w_en_in=0 upstream; the stage does not mask them.
- Wrap-around: pc and address arithmetic are modulo 2^32. A negative imm24 sign-extends from bit 23.

## Configuration
- `FORWARDING_EN` defined: sel_src1/sel_src2 steer the operand muxes.
- Not defined: the muxes are removed, operands come from val_rn_in/val_rm_in only, and the sel and fwd ports remain but are ignored.

## Structure
- A shared package `arm_pkg` holds:
  - exec_cmd localparams: CMD_MOV, CMD_MVN, CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC, CMD_AND, CMD_ORR, CMD_EOR
  - shift-type constants: SH_LSL, SH_LSR, SH_ASR, SH_ROR
  - forwarding select codes
- Sub-module `val2_gen`: combinational shifter/rotator, instantiated once. The ALU and registers stay in exe_stage.

## Test plan
- Reset: assert rst mid-stream → all outputs 0 immediately; status=0000.
- ADD with overflow and flag write: Rn=0x7FFFFFFF, imm so=0x001, status_w_en=1 → alu_res=0x80000000, status=1001 (N=1, Z=0, C=0, V=1).
- CMP equal: Rn=5, Val2=5, wb_en=0, status_w_en=1 → status=0110 (Z=1, C=1), wb_en=0 at the output.
- Val2 generation:
  - imm so=0x4FF → Val2=0xFF000000.
  - Register so: shift_imm=4, ASR, Rm=0x80000000 → Val2=0xF8000000.
  - LDR with so=0xFFF → Val2=0x00000FFF.
- Branch: pc_in=0x100, imm24=0xFFFFFE → branch_addr=0xF8, branch_taken follows branch_taken_in in the same cycle.
- Freeze and forwarding:
  - freeze=1 with new inputs → outputs and status hold.
  - With `FORWARDING_EN`, sel_src1=01 and mem_fwd_val=7: ADD with imm 1 → alu_res=8.
